// File: rtl/mmio_peripheral_bank.sv
// Memory-mapped store target: scratch register bank plus a FIFO-backed TX port.
// Each store completes with a one-cycle write_complete pulse after a fixed latency.
module mmio_peripheral_bank #(
   parameter int unsigned    XLEN             = 32,
   parameter logic [XLEN-1:0] BASE_ADDR       = XLEN'(32'h0001_0000),
   parameter int unsigned    NUM_REGS         = 8,
   parameter int unsigned    COMPLETE_LATENCY = 5,
   parameter int unsigned    FIFO_DEPTH       = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] mmio_addr,
   input  logic [XLEN-1:0] mmio_value,
   input  logic [1:0]      mmio_width,
   input  logic            mmio_enable,
   output logic [XLEN-1:0] mmio_r_data,
   output logic            mmio_write_complete,
   output logic            tx_valid,
   output logic [XLEN-1:0] tx_data,
   input  logic            tx_ready,
   output logic            err
);

   localparam int unsigned CNT_W  = $clog2(COMPLETE_LATENCY + 1);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(COMPLETE_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   addr_q, value_q;
   logic [1:0]        width_q;
   logic              load, commit, reached, blocked;
   logic [XLEN-1:0]   regs_q [NUM_REGS];
   logic              err_q, wc_q;
   logic [XLEN-1:0]   fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FCNT_W-1:0] fcount_q;
   logic              fifo_full, fifo_empty, push, pop;

   // Request seen by decode: live inputs while idle, latched copy afterwards
   logic [XLEN-1:0] req_addr, req_value, req_off, req_idx;
   logic [1:0]      req_width;
   logic            req_hit, req_tx, req_align, req_ok;
   logic [XLEN-1:0] lane_val, lane_mask, wr_data, wr_mask;

   always_comb begin
      req_addr  = (state_q == S_IDLE) ? mmio_addr  : addr_q;
      req_value = (state_q == S_IDLE) ? mmio_value : value_q;
      req_width = (state_q == S_IDLE) ? mmio_width : width_q;
      req_off   = req_addr - BASE_ADDR;
      req_idx   = req_off >> 2;
      req_hit   = req_idx <= XLEN'(NUM_REGS);
      req_tx    = req_idx == XLEN'(NUM_REGS);
      lane_val  = req_value;
      lane_mask = '1;
      req_align = 1'b0;
      case (req_width)
         2'd0: begin
            lane_val  = XLEN'(req_value[7:0]);
            lane_mask = XLEN'(8'hFF);
            req_align = 1'b1;
         end
         2'd1: begin
            lane_val  = XLEN'(req_value[15:0]);
            lane_mask = XLEN'(16'hFFFF);
            req_align = ~req_addr[0];
         end
         2'd2:    req_align = (req_addr[1:0] == 2'b00);
         default: req_align = 1'b0;
      endcase
      req_ok  = req_hit & req_align;
      wr_data = lane_val  << {req_addr[1:0], 3'b000};
      wr_mask = lane_mask << {req_addr[1:0], 3'b000};
   end

   assign fifo_full  = (fcount_q == FCNT_W'(FIFO_DEPTH));
   assign fifo_empty = (fcount_q == '0);
   assign pop        = ~fifo_empty & tx_ready;
   assign blocked    = req_ok & req_tx & fifo_full & ~pop;
   assign push       = commit & req_ok & req_tx;

   // Sequencer state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state; the commit edge is the one on which the counter would reach the latency
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      commit  = 1'b0;
      reached = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mmio_enable) begin
               load    = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = S_WAIT;
               reached = (COMPLETE_LATENCY == 1);
            end
         end
         S_WAIT: begin
            reached = (cnt_q >= LAT_M1);
            if (!reached) cnt_d = cnt_q + CNT_W'(1);
         end
         S_HOLD: begin
            if (!mmio_enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (reached && !blocked) begin
         commit  = 1'b1;
         state_d = S_HOLD;
      end
   end

   // Datapath: latches, register bank, error flag, FIFO pointers
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q   <= '0;
         value_q  <= '0;
         width_q  <= '0;
         err_q    <= 1'b0;
         wc_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcount_q <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         wc_q <= commit;
         if (load) begin
            addr_q  <= mmio_addr;
            value_q <= mmio_value;
            width_q <= mmio_width;
         end
         if (commit && !req_ok) err_q <= 1'b1;
         if (commit && req_ok && !req_tx) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
               if (req_idx == XLEN'(i)) regs_q[i] <= (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
         end
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      fcount_q <= fcount_q + FCNT_W'(1);
         else if (pop && !push) fcount_q <= fcount_q - FCNT_W'(1);
      end
   end

   // FIFO storage needs no reset: contents are only visible through tx_valid
   always_ff @(posedge clock) begin
      if (push) fifo_q[wr_ptr_q] <= lane_val;
   end

   // Readback decode
   logic [XLEN-1:0] rd_off, rd_idx;
   always_comb begin
      rd_off      = mmio_addr - BASE_ADDR;
      rd_idx      = rd_off >> 2;
      mmio_r_data = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)
         if (rd_idx == XLEN'(i)) mmio_r_data = regs_q[i];
      if (rd_idx == XLEN'(NUM_REGS))
         mmio_r_data = XLEN'({fcount_q, 5'b00000, err_q, fifo_full, fifo_empty});
   end

   assign mmio_write_complete = wc_q;
   assign tx_valid            = ~fifo_empty;
   assign tx_data             = fifo_q[rd_ptr_q];
   assign err                 = err_q;

endmodule

// File: tb/tb_mmio_peripheral_bank.sv
// Directed bench for mmio_peripheral_bank: register lanes, error cases, TX backpressure, reset abort.
module tb_mmio_peripheral_bank;

   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam logic [31:0] TX   = BASE + 32'd32;

   logic        clock, reset;
   logic [31:0] mmio_addr, mmio_value, mmio_r_data, tx_data;
   logic [1:0]  mmio_width;
   logic        mmio_enable, mmio_write_complete, tx_valid, tx_ready, err;

   int n_checks = 0;
   int n_fail   = 0;

   mmio_peripheral_bank dut (
      .clock(clock), .reset(reset),
      .mmio_addr(mmio_addr), .mmio_value(mmio_value), .mmio_width(mmio_width),
      .mmio_enable(mmio_enable), .mmio_r_data(mmio_r_data),
      .mmio_write_complete(mmio_write_complete),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      mmio_addr = a;
      #1;
      check(tag, mmio_r_data, exp);
   endtask

   // Store with enable held for 'hold' cycles after the pulse; checks latency and pulse width
   task automatic store(input string tag, input logic [31:0] a, input logic [31:0] v,
                        input logic [1:0] w, input int hold);
      int n;
      int pulses;
      mmio_addr = a; mmio_value = v; mmio_width = w; mmio_enable = 1'b1;
      @(posedge clock);
      n = 1;
      @(negedge clock);
      while (!mmio_write_complete && n < 40) begin
         @(negedge clock);
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'd5);
      pulses = 0;
      repeat (hold) begin
         @(negedge clock);
         if (mmio_write_complete) pulses++;
      end
      check({tag, " extra pulses"}, 32'(pulses), 32'd0);
      mmio_enable = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      int pulses;
      reset = 1'b1; mmio_enable = 1'b0; tx_ready = 1'b0;
      mmio_addr = '0; mmio_value = '0; mmio_width = 2'd2;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset wc", 32'(mmio_write_complete), 32'd0);
      check("reset tx_valid", 32'(tx_valid), 32'd0);
      check("reset err", 32'(err), 32'd0);
      read_check("reset reg1", BASE + 32'd4, 32'h0);
      read_check("reset status", TX, 32'h1);

      // Word store with enable held long after the pulse
      store("word", BASE + 32'd4, 32'hDEAD_BEEF, 2'd2, 8);
      read_check("word reg1", BASE + 32'd4, 32'hDEAD_BEEF);

      // Byte and half lane merges
      store("byte", BASE + 32'd6, 32'h0000_00AB, 2'd0, 1);
      read_check("byte reg1", BASE + 32'd4, 32'hDEAB_BEEF);
      store("half", BASE + 32'd4, 32'h0000_1234, 2'd1, 1);
      read_check("half reg1", BASE + 32'd4, 32'hDEAB_1234);
      check("err clean", 32'(err), 32'd0);

      // Misaligned and unmapped stores
      store("misaligned", BASE + 32'd1, 32'h0000_FFFF, 2'd1, 1);
      read_check("misaligned reg0", BASE, 32'h0);
      read_check("misaligned reg1", BASE + 32'd4, 32'hDEAB_1234);
      check("err misaligned", 32'(err), 32'd1);
      store("unmapped", BASE + 32'h100, 32'h1111_1111, 2'd2, 1);
      check("err sticky", 32'(err), 32'd1);
      read_check("status err", TX, 32'h5);

      // Fill TX FIFO with no downstream ready
      for (int i = 1; i <= 4; i++) store("tx fill", TX, 32'(i), 2'd2, 1);
      read_check("status full", TX, 32'h406);
      check("head 1", tx_data, 32'd1);

      // Fifth push stalls until one pop
      mmio_addr = TX; mmio_value = 32'd5; mmio_width = 2'd2; mmio_enable = 1'b1;
      @(posedge clock);
      pulses = 0;
      repeat (10) begin
         @(negedge clock);
         if (mmio_write_complete) pulses++;
      end
      check("stall pulses", 32'(pulses), 32'd0);
      check("stall head", tx_data, 32'd1);
      tx_ready = 1'b1;
      @(negedge clock);
      check("unstall wc", 32'(mmio_write_complete), 32'd1);
      tx_ready = 1'b0;
      read_check("unstall status", TX, 32'h406);
      mmio_enable = 1'b0;
      @(negedge clock);
      check("unstall wc low", 32'(mmio_write_complete), 32'd0);
      for (int i = 2; i <= 5; i++) begin
         check("drain valid", 32'(tx_valid), 32'd1);
         check("drain data", tx_data, 32'(i));
         tx_ready = 1'b1;
         @(negedge clock);
         tx_ready = 1'b0;
      end
      check("drained valid", 32'(tx_valid), 32'd0);
      read_check("drained status", TX, 32'h5);

      // Full FIFO, pop coincides with the commit edge
      for (int i = 10; i <= 13; i++) store("tx refill", TX, 32'(i), 2'd2, 1);
      mmio_addr = TX; mmio_value = 32'd14; mmio_width = 2'd2; mmio_enable = 1'b1;
      @(posedge clock);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("pre-commit wc", 32'(mmio_write_complete), 32'd0);
      tx_ready = 1'b1;
      @(negedge clock);
      check("pushpop wc", 32'(mmio_write_complete), 32'd1);
      tx_ready = 1'b0;
      check("pushpop head", tx_data, 32'd11);
      read_check("pushpop status", TX, 32'h406);
      mmio_enable = 1'b0;
      @(negedge clock);

      // Reset two edges into WAIT
      mmio_addr = BASE + 32'd8; mmio_value = 32'h55; mmio_width = 2'd2; mmio_enable = 1'b1;
      @(posedge clock);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1; mmio_enable = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(negedge clock);
         if (mmio_write_complete) pulses++;
      end
      check("abort pulses", 32'(pulses), 32'd0);
      read_check("abort reg2", BASE + 32'd8, 32'h0);
      read_check("abort reg1", BASE + 32'd4, 32'h0);
      read_check("abort status", TX, 32'h1);
      check("abort tx_valid", 32'(tx_valid), 32'd0);
      check("abort err", 32'(err), 32'd0);
      store("post reset", BASE + 32'd8, 32'h77, 2'd2, 1);
      read_check("post reset reg2", BASE + 32'd8, 32'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
